// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry output queue.
// Optional PC-relative target adder enabled by `define IMM_TARGET_ADDER_EN.
module imm_extend_pipe #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_ins,
  input  logic [2:0]      i_in_ext_cnt,
  input  logic [XLEN-1:0] i_in_pc,
  input  logic            i_flush,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_imm,
  output logic [XLEN-1:0] o_out_target,
  output logic            o_out_illegal
);

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;
  logic            w_tail;
  logic            w_unused_ins;

  logic [XLEN-1:0] r_imm [2];
  logic            r_ill [2];
  logic            r_head;
  logic [1:0]      r_cnt;

  assign w_unused_ins = ^i_in_ins[6:0];

  // Zero-extended modes leave bit 31 clear, so one sign extension covers every mode.
  always_comb begin
    w_imm32   = '0;
    w_illegal = 1'b0;
    case (i_in_ext_cnt)
      3'b000: w_imm32 = {{20{i_in_ins[31]}}, i_in_ins[31:20]};
      3'b001: w_imm32 = {{20{i_in_ins[31]}}, i_in_ins[31:25], i_in_ins[11:7]};
      3'b010: w_imm32 = {{19{i_in_ins[31]}}, i_in_ins[31], i_in_ins[7],
                         i_in_ins[30:25], i_in_ins[11:8], 1'b0};
      3'b011: w_imm32 = {i_in_ins[31:12], 12'b0};
      3'b100: w_imm32 = {{11{i_in_ins[31]}}, i_in_ins[31], i_in_ins[19:12],
                         i_in_ins[20], i_in_ins[30:21], 1'b0};
      3'b101: w_imm32 = {20'b0, i_in_ins[31:20]};
      3'b110: w_imm32 = {27'b0, i_in_ins[19:15]};
      default: begin
        if (XLEN == 64) begin
          w_imm32 = {26'b0, i_in_ins[25:20]};
        end else if (i_in_ins[25]) begin
          w_illegal = 1'b1;
        end else begin
          w_imm32 = {27'b0, i_in_ins[24:20]};
        end
      end
    endcase
    w_imm       = {XLEN{w_imm32[31]}};
    w_imm[31:0] = w_imm32;
  end

  assign o_in_ready  = (r_cnt != 2'd2);
  assign o_out_valid = (r_cnt != 2'd0);
  assign w_push      = i_in_valid & o_in_ready & ~i_flush;
  assign w_pop       = o_out_valid & i_out_ready & ~i_flush;
  assign w_tail      = r_head ^ r_cnt[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= 2'd0;
      r_head <= 1'b0;
      r_imm  <= '{default: '0};
      r_ill  <= '{default: 1'b0};
    end else begin
      if (i_flush) begin
        r_cnt <= 2'd0;
      end else if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_push) begin
        r_imm[w_tail] <= w_imm;
        r_ill[w_tail] <= w_illegal;
      end
    end
  end

  assign o_out_imm     = r_imm[r_head];
  assign o_out_illegal = r_ill[r_head];

`ifdef IMM_TARGET_ADDER_EN
  logic [XLEN-1:0] r_tgt [2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tgt <= '{default: '0};
    end else if (w_push) begin
      r_tgt[w_tail] <= i_in_pc + w_imm;
    end
  end

  assign o_out_target = r_tgt[r_head];
`else
  logic w_unused_pc;

  assign w_unused_pc  = ^i_in_pc;
  assign o_out_target = '0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: scoreboarded XLEN=32 instance plus directed XLEN=64 checks.
// Target expectations follow `define IMM_TARGET_ADDER_EN.
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        ill;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins;
  logic [2:0]  in_mode;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [31:0] out_tgt;
  logic        out_ill;

  logic        v64_in_valid;
  logic        v64_in_ready;
  logic [31:0] v64_in_ins;
  logic [2:0]  v64_in_mode;
  logic [63:0] v64_in_pc;
  logic        v64_out_valid;
  logic [63:0] v64_out_imm;
  logic [63:0] v64_out_tgt;
  logic        v64_out_ill;

  int   n_chk;
  int   n_fail;
  sb_t  sb[$];

  imm_extend_pipe #(.XLEN(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_ins(in_ins), .i_in_ext_cnt(in_mode), .i_in_pc(in_pc),
    .i_flush(flush),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_imm(out_imm), .o_out_target(out_tgt), .o_out_illegal(out_ill)
  );

  imm_extend_pipe #(.XLEN(64)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(v64_in_valid), .o_in_ready(v64_in_ready),
    .i_in_ins(v64_in_ins), .i_in_ext_cnt(v64_in_mode), .i_in_pc(v64_in_pc),
    .i_flush(1'b0),
    .o_out_valid(v64_out_valid), .i_out_ready(1'b1),
    .o_out_imm(v64_out_imm), .o_out_target(v64_out_tgt), .o_out_illegal(v64_out_ill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference immediate built from shifts of the sign-extended instruction word.
  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] m,
                                            input int xl, output logic ill);
    longint     s;
    logic [63:0] v;
    s   = $signed(ins);
    ill = 1'b0;
    v   = '0;
    case (m)
      3'd0: v = s >>> 20;
      3'd1: v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
              | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: v = s & ~64'hFFF;
      3'd4: v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
              | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      3'd5: v = longint'(ins >> 20);
      3'd6: v = longint'(ins[19:15]);
      default: begin
        if (xl == 32 && ins[25]) begin
          ill = 1'b1;
          v   = '0;
        end else if (xl == 32) begin
          v = longint'(ins[24:20]);
        end else begin
          v = longint'(ins[25:20]);
        end
      end
    endcase
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // Scoreboard: compare head on pop, record expectation on accept, clear on flush.
  always @(negedge clk) begin
    sb_t         e;
    logic        ill;
    logic [63:0] im;
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_pop", 64'(out_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("sb_imm", 64'(out_imm), 64'(e.imm));
            chk("sb_tgt", 64'(out_tgt), 64'(e.tgt));
            chk("sb_ill", 64'(out_ill), 64'(e.ill));
          end
        end
        if (in_valid && in_ready) begin
          im    = model_imm(in_ins, in_mode, 32, ill);
          e.imm = im[31:0];
          e.ill = ill;
`ifdef IMM_TARGET_ADDER_EN
          e.tgt = in_pc + im[31:0];
`else
          e.tgt = 32'h0;
`endif
          sb.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] m, input logic [31:0] pc);
    in_valid = 1'b1;
    in_ins   = ins;
    in_mode  = m;
    in_pc    = pc;
  endtask

  initial begin
    logic        ill64;
    logic [63:0] exp64;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_ins = '0; in_mode = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    v64_in_valid = 1'b0; v64_in_ins = '0; v64_in_mode = '0; v64_in_pc = '0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_imm", 64'(out_imm), 64'(0));
    chk("rst_tgt", 64'(out_tgt), 64'(0));
    chk("rst_ill", 64'(out_ill), 64'(0));
    rst_n = 1'b1;
    step();

    // addi x1,x0,-1 : one-cycle latency
    drive(32'hFFF0_0093, 3'b000, 32'h0);
    chk("t1_pre_valid", 64'(out_valid), 64'(0));
    step();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("t1_ill", 64'(out_ill), 64'(0));
    out_ready = 1'b1;
    step();
    chk("t1_drained", 64'(out_valid), 64'(0));

    // beq -4 at PC 0x100
    drive(32'hFE00_0EE3, 3'b010, 32'h100);
    step();
    in_valid = 1'b0;
    chk("t2_imm", 64'(out_imm), 64'hFFFF_FFFC);
`ifdef IMM_TARGET_ADDER_EN
    chk("t2_tgt", 64'(out_tgt), 64'h0000_00FC);
`else
    chk("t2_tgt", 64'(out_tgt), 64'h0);
`endif
    step();

    // Backpressure: A, B fill the queue, C is held until a slot frees
    out_ready = 1'b0;
    drive(32'h1234_5093, 3'b000, 32'h10);
    step();
    chk("bp_ready_1", 64'(in_ready), 64'(1));
    drive(32'h8000_1423, 3'b001, 32'h20);
    step();
    chk("bp_ready_full", 64'(in_ready), 64'(0));
    chk("bp_head_a", 64'(out_imm), 64'h0000_0123);
    drive(32'hFFF0_0000, 3'b101, 32'h30);
    step();
    step();
    chk("bp_ready_held", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    step();
    chk("bp_ready_after_pop", 64'(in_ready), 64'(1));
    chk("bp_head_b", 64'(out_imm), 64'hFFFF_F808);
    step();
    in_valid = 1'b0;
    chk("bp_head_c", 64'(out_imm), 64'h0000_0FFF);
    chk("bp_valid_c", 64'(out_valid), 64'(1));
    step();
    chk("bp_empty", 64'(out_valid), 64'(0));

    // shamt: illegal with bit 25 set on XLEN=32, legal on XLEN=64
    drive(32'h0200_9093, 3'b111, 32'h40);
    v64_in_valid = 1'b1; v64_in_ins = 32'h0200_9093; v64_in_mode = 3'b111;
    v64_in_pc = 64'h1000;
    step();
    chk("sh32_imm", 64'(out_imm), 64'h0);
    chk("sh32_ill", 64'(out_ill), 64'(1));
    chk("sh64_imm", v64_out_imm, 64'd32);
    chk("sh64_ill", 64'(v64_out_ill), 64'(0));
`ifdef IMM_TARGET_ADDER_EN
    chk("sh64_tgt", v64_out_tgt, 64'h1020);
`else
    chk("sh64_tgt", v64_out_tgt, 64'h0);
`endif
    drive(32'h0050_9093, 3'b111, 32'h44);
    v64_in_ins = 32'h8000_02B7; v64_in_mode = 3'b011;
    v64_in_pc = 64'hFFFF_FFFF_FFFF_FFF0;
    step();
    chk("sh32_legal_imm", 64'(out_imm), 64'd5);
    chk("sh32_legal_ill", 64'(out_ill), 64'(0));
    chk("lui64_imm", v64_out_imm, 64'hFFFF_FFFF_8000_0000);
    exp64 = model_imm(32'h8000_02B7, 3'b011, 64, ill64);
`ifdef IMM_TARGET_ADDER_EN
    chk("lui64_tgt", v64_out_tgt, 64'hFFFF_FFFF_FFFF_FFF0 + exp64);
`else
    chk("lui64_tgt", v64_out_tgt, 64'h0);
`endif
    v64_in_ins = 32'hFFFF_F0EF; v64_in_mode = 3'b100;
    step();
    v64_in_valid = 1'b0;
    exp64 = model_imm(32'hFFFF_F0EF, 3'b100, 64, ill64);
    chk("jal64_imm", v64_out_imm, exp64);

    // Streaming random beats at full throughput
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 24; i++) begin
      drive($urandom, 3'($urandom_range(0, 7)), $urandom);
      step();
      chk("stream_ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_drained", 64'(sb.size()), 64'(0));

    // Flush with a simultaneous push while full
    out_ready = 1'b0;
    drive(32'h0010_0093, 3'b000, 32'h0);
    step();
    drive(32'h0020_0093, 3'b000, 32'h0);
    step();
    chk("fl_full", 64'(in_ready), 64'(0));
    flush = 1'b1;
    drive(32'h0030_0093, 3'b000, 32'h0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    step();
    step();
    chk("fl_no_ghost", 64'(out_valid), 64'(0));

    // Asynchronous reset mid-cycle with two entries held
    out_ready = 1'b0;
    drive(32'h8000_02B7, 3'b011, 32'h4);
    step();
    drive(32'hFFF0_0093, 3'b000, 32'h8);
    step();
    in_valid = 1'b0;
    chk("ar_full", 64'(in_ready), 64'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'(0));
    chk("ar_ready", 64'(in_ready), 64'(1));
    chk("ar_imm", 64'(out_imm), 64'h0);
    chk("ar_tgt", 64'(out_tgt), 64'h0);
    chk("ar_ill", 64'(out_ill), 64'(0));
    chk("ar_v64", 64'(v64_out_valid), 64'(0));
    @(negedge clk);
    sb.delete();
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_post_valid", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
